// File: rtl/uart_tx_arb_pkg.sv
// Shared definitions for the UART transmit arbiter: FSM state codes, byte-count width helper, default timeout.
// The optional tx_busy timeout is enabled by defining UART_TX_ARB_TIMEOUT_EN.
package uart_tx_arb_pkg;

    localparam logic [2:0] ST_IDLE       = 3'd0;
    localparam logic [2:0] ST_GRANT      = 3'd1;
    localparam logic [2:0] ST_SEND       = 3'd2;
    localparam logic [2:0] ST_WAIT_START = 3'd3;
    localparam logic [2:0] ST_WAIT_DONE  = 3'd4;
    localparam logic [2:0] ST_ACK        = 3'd5;

    localparam int unsigned DEFAULT_TIMEOUT_CYCLES = 64;

    // Bits needed to hold a byte count in the range 0..max_bytes inclusive.
    function automatic int unsigned byte_cnt_width(input int unsigned max_bytes);
        return $clog2(max_bytes + 1);
    endfunction

endpackage

// File: rtl/uart_tx_arbiter_rr_priority_picker.sv
// Combinational round-robin select: first requester at or after ptr, wrapping modulo NUM_REQ.
// Produces a one-hot grant, its index, and a flag that any request was found.
module rr_priority_picker #(
    parameter int unsigned NUM_REQ = 2,
    localparam int unsigned IDX_W = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   ptr,
    output logic [NUM_REQ-1:0] grant,
    output logic [IDX_W-1:0]   idx,
    output logic               found
);

    always_comb begin
        int unsigned j;
        grant = '0;
        idx   = '0;
        found = 1'b0;
        j     = 0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            j = (int'(ptr) + i) % NUM_REQ;
            if (!found && req[j]) begin
                grant[j] = 1'b1;
                idx      = IDX_W'(j);
                found    = 1'b1;
            end
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART transmitter among NUM_REQ requesters, sending messages LSB byte first.
// Define UART_TX_ARB_TIMEOUT_EN to abort a message when tx_busy fails to rise within TIMEOUT_CYCLES.
module uart_tx_arbiter
    import uart_tx_arb_pkg::*;
#(
    parameter int unsigned DATA_WIDTH     = 8,
    parameter int unsigned NUM_REQ        = 2,
    parameter int unsigned MAX_BYTES      = 2,
    parameter int unsigned TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES,
    localparam int unsigned CNT_W = byte_cnt_width(MAX_BYTES),
    localparam int unsigned IDX_W = $clog2(NUM_REQ),
    localparam int unsigned MSG_W = MAX_BYTES * DATA_WIDTH
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [NUM_REQ-1:0]         req,
    input  logic [NUM_REQ*MSG_W-1:0]   req_data,
    input  logic [NUM_REQ*CNT_W-1:0]   req_bytes,
    output logic [NUM_REQ-1:0]         req_ack,
    input  logic                       tx_busy,
    output logic                       tx_data_valid,
    output logic [DATA_WIDTH-1:0]      tx_parallel_data,
    output logic                       arb_busy,
    output logic [IDX_W-1:0]           grant_id,
    output logic                       timeout_error
);

    if (NUM_REQ < 2 || NUM_REQ > 8 || MAX_BYTES < 1 || TIMEOUT_CYCLES < 1) begin : g_cfg_check
        $error("uart_tx_arbiter: unsupported parameter set");
    end

    logic [2:0]            state;
    logic [IDX_W-1:0]      ptr;
    logic [NUM_REQ-1:0]    grant_oh;
    logic [MSG_W-1:0]      msg_data;
    logic [CNT_W-1:0]      msg_count;
    logic [CNT_W-1:0]      byte_idx;
    logic [CNT_W-1:0]      next_idx;
    logic [NUM_REQ-1:0]    pick_oh;
    logic [IDX_W-1:0]      pick_idx;
    logic                  pick_found;
    logic [CNT_W-1:0]      sel_count;
    logic [MSG_W-1:0]      sel_data;
    logic [DATA_WIDTH-1:0] cur_byte;
    logic [DATA_WIDTH-1:0] next_byte;

`ifdef UART_TX_ARB_TIMEOUT_EN
    localparam int unsigned TMR_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [TMR_W-1:0] timer;
`else
    assign timeout_error = 1'b0;
`endif

    rr_priority_picker #(
        .NUM_REQ(NUM_REQ)
    ) u_picker (
        .req  (req),
        .ptr  (ptr),
        .grant(pick_oh),
        .idx  (pick_idx),
        .found(pick_found)
    );

    // Oversized counts are clamped so the byte index never walks past the latched message.
    always_comb begin
        sel_count = req_bytes[int'(pick_idx)*CNT_W +: CNT_W];
        if (sel_count > CNT_W'(MAX_BYTES)) begin
            sel_count = CNT_W'(MAX_BYTES);
        end
        sel_data  = req_data[int'(pick_idx)*MSG_W +: MSG_W];
        next_idx  = byte_idx + CNT_W'(1);
        cur_byte  = msg_data[int'(byte_idx)*DATA_WIDTH +: DATA_WIDTH];
        next_byte = msg_data[int'(next_idx)*DATA_WIDTH +: DATA_WIDTH];
    end

    assign arb_busy = (state != ST_IDLE);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state            <= ST_IDLE;
            ptr              <= '0;
            grant_oh         <= '0;
            grant_id         <= '0;
            msg_data         <= '0;
            msg_count        <= '0;
            byte_idx         <= '0;
            req_ack          <= '0;
            tx_data_valid    <= 1'b0;
            tx_parallel_data <= '0;
`ifdef UART_TX_ARB_TIMEOUT_EN
            timer            <= '0;
            timeout_error    <= 1'b0;
`endif
        end else begin
            req_ack <= '0;
            case (state)
                ST_IDLE: begin
                    if (pick_found && !tx_busy) begin
                        grant_id  <= pick_idx;
                        grant_oh  <= pick_oh;
                        msg_data  <= sel_data;
                        msg_count <= sel_count;
                        byte_idx  <= '0;
                        state     <= ST_GRANT;
                    end
                end
                ST_GRANT: begin
                    if (msg_count == '0) begin
                        req_ack <= grant_oh;
                        state   <= ST_ACK;
                    end else begin
                        tx_parallel_data <= cur_byte;
                        state            <= ST_SEND;
                    end
                end
                ST_SEND: begin
                    if (!tx_busy) begin
                        tx_data_valid <= 1'b1;
                        state         <= ST_WAIT_START;
`ifdef UART_TX_ARB_TIMEOUT_EN
                        timer         <= '0;
`endif
                    end
                end
                ST_WAIT_START: begin
                    if (tx_busy) begin
                        tx_data_valid <= 1'b0;
                        state         <= ST_WAIT_DONE;
                    end
`ifdef UART_TX_ARB_TIMEOUT_EN
                    else if (timer == TMR_W'(TIMEOUT_CYCLES - 1)) begin
                        tx_data_valid <= 1'b0;
                        timeout_error <= 1'b1;
                        req_ack       <= grant_oh;
                        state         <= ST_ACK;
                    end else begin
                        timer <= timer + TMR_W'(1);
                    end
`endif
                end
                ST_WAIT_DONE: begin
                    if (!tx_busy) begin
                        byte_idx <= next_idx;
                        if (next_idx == msg_count) begin
                            req_ack <= grant_oh;
                            state   <= ST_ACK;
                        end else begin
                            tx_parallel_data <= next_byte;
                            state            <= ST_SEND;
                        end
                    end
                end
                ST_ACK: begin
                    ptr   <= (grant_id == IDX_W'(NUM_REQ - 1)) ? '0 : grant_id + IDX_W'(1);
                    state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed self-checking bench for uart_tx_arbiter (2 requesters, 2-byte messages, 8-bit bytes).
// Timeout steps run only when UART_TX_ARB_TIMEOUT_EN is defined; otherwise the indefinite wait is checked.
module tb_uart_tx_arbiter;

    localparam int unsigned DW = 8;
    localparam int unsigned NR = 2;
    localparam int unsigned MB = 2;
    localparam int unsigned CW = 2;
    localparam int unsigned IW = 1;

    logic                clk = 1'b0;
    logic                reset;
    logic [NR-1:0]       req;
    logic [NR*MB*DW-1:0] req_data;
    logic [NR*CW-1:0]    req_bytes;
    logic [NR-1:0]       req_ack;
    logic                tx_busy;
    logic                tx_data_valid;
    logic [DW-1:0]       tx_parallel_data;
    logic                arb_busy;
    logic [IW-1:0]       grant_id;
    logic                timeout_error;

    int checks = 0;
    int errors = 0;

    uart_tx_arbiter #(
        .DATA_WIDTH    (DW),
        .NUM_REQ       (NR),
        .MAX_BYTES     (MB),
        .TIMEOUT_CYCLES(64)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .req             (req),
        .req_data        (req_data),
        .req_bytes       (req_bytes),
        .req_ack         (req_ack),
        .tx_busy         (tx_busy),
        .tx_data_valid   (tx_data_valid),
        .tx_parallel_data(tx_parallel_data),
        .arb_busy        (arb_busy),
        .grant_id        (grant_id),
        .timeout_error   (timeout_error)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Transmitter model: busy rises 'delay' cycles after valid is first seen, stays high 'len' cycles.
    task automatic serve_byte(input string tag, input logic [7:0] exp, input int delay, input int len);
        chk({tag, "_valid_up"}, 32'(tx_data_valid), 32'd1);
        chk({tag, "_data"}, 32'(tx_parallel_data), 32'(exp));
        for (int i = 1; i < delay; i++) begin
            tick();
            chk({tag, "_valid_hold"}, 32'(tx_data_valid), 32'd1);
            chk({tag, "_data_hold"}, 32'(tx_parallel_data), 32'(exp));
        end
        tx_busy = 1'b1;
        for (int k = 0; k < len; k++) begin
            tick();
            chk({tag, "_valid_low"}, 32'(tx_data_valid), 32'd0);
            chk({tag, "_data_stable"}, 32'(tx_parallel_data), 32'(exp));
            chk({tag, "_no_ack"}, 32'(req_ack), 32'd0);
        end
        tx_busy = 1'b0;
    endtask

    initial begin
        reset     = 1'b1;
        req       = '0;
        req_data  = '0;
        req_bytes = '0;
        tx_busy   = 1'b0;
        tick();
        tick();
        chk("rst_valid", 32'(tx_data_valid), 32'd0);
        chk("rst_data", 32'(tx_parallel_data), 32'd0);
        chk("rst_ack", 32'(req_ack), 32'd0);
        chk("rst_busy", 32'(arb_busy), 32'd0);
        chk("rst_gid", 32'(grant_id), 32'd0);
        chk("rst_terr", 32'(timeout_error), 32'd0);
        reset = 1'b0;

        // Single 2-byte message from requester 0, 11-cycle busy per byte
        req_data  = 32'h0000_A55A;
        req_bytes = 4'b0010;
        req       = 2'b01;
        tick();
        chk("t1_busy", 32'(arb_busy), 32'd1);
        chk("t1_gid", 32'(grant_id), 32'd0);
        chk("t1_valid_grant", 32'(tx_data_valid), 32'd0);
        tick();
        chk("t1_data0", 32'(tx_parallel_data), 32'h5A);
        chk("t1_valid_send", 32'(tx_data_valid), 32'd0);
        tick();
        serve_byte("t1b0", 8'h5A, 1, 11);
        tick();
        chk("t1_data1", 32'(tx_parallel_data), 32'hA5);
        chk("t1_valid_send1", 32'(tx_data_valid), 32'd0);
        chk("t1_no_early_ack", 32'(req_ack), 32'd0);
        tick();
        serve_byte("t1b1", 8'hA5, 1, 11);
        tick();
        chk("t1_ack", 32'(req_ack), 32'b01);
        req = 2'b00;
        tick();
        chk("t1_ack_once", 32'(req_ack), 32'd0);
        chk("t1_idle", 32'(arb_busy), 32'd0);

        reset = 1'b1;
        tick();
        reset = 1'b0;

        // Contention: both held high, 1 byte each, grants must alternate from pointer 0
        req_data  = 32'h0022_0011;
        req_bytes = 4'b0101;
        req       = 2'b11;
        for (int m = 0; m < 4; m++) begin
            tick();
            chk("t2_gid", 32'(grant_id), 32'(m % 2));
            tick();
            chk("t2_data", 32'(tx_parallel_data), (m % 2 == 1) ? 32'h22 : 32'h11);
            tick();
            serve_byte("t2", (m % 2 == 1) ? 8'h22 : 8'h11, 1, 2);
            tick();
            chk("t2_ack", 32'(req_ack), (m % 2 == 1) ? 32'b10 : 32'b01);
            if (m == 3) req = 2'b00;
            tick();
            chk("t2_ack_clr", 32'(req_ack), 32'd0);
        end

        // Zero-byte message: ack two cycles after req, no valid
        req_bytes = 4'b0000;
        req       = 2'b01;
        tick();
        chk("t3_gid", 32'(grant_id), 32'd0);
        chk("t3_no_ack", 32'(req_ack), 32'd0);
        chk("t3_valid0", 32'(tx_data_valid), 32'd0);
        tick();
        chk("t3_ack", 32'(req_ack), 32'b01);
        chk("t3_valid1", 32'(tx_data_valid), 32'd0);
        req = 2'b00;
        tick();
        chk("t3_ack_clr", 32'(req_ack), 32'd0);
        chk("t3_idle", 32'(arb_busy), 32'd0);

        // Reset during WAIT_DONE of byte 0 for requester 1 (pointer is 1 here)
        req_data  = 32'h1234_0000;
        req_bytes = 4'b1000;
        req       = 2'b11;
        tick();
        chk("t4_gid1", 32'(grant_id), 32'd1);
        tick();
        chk("t4_data", 32'(tx_parallel_data), 32'h34);
        tick();
        chk("t4_valid", 32'(tx_data_valid), 32'd1);
        tx_busy = 1'b1;
        tick();
        chk("t4_wait_done", 32'(tx_data_valid), 32'd0);
        reset = 1'b1;
        #1;
        chk("t4_rst_valid", 32'(tx_data_valid), 32'd0);
        chk("t4_rst_data", 32'(tx_parallel_data), 32'd0);
        chk("t4_rst_busy", 32'(arb_busy), 32'd0);
        chk("t4_rst_gid", 32'(grant_id), 32'd0);
        chk("t4_rst_ack", 32'(req_ack), 32'd0);
        tx_busy = 1'b0;
        tick();
        reset = 1'b0;
        chk("t4_rel_idle", 32'(arb_busy), 32'd0);
        tick();
        chk("t4_ptr0_gid", 32'(grant_id), 32'd0);
        chk("t4_ptr0_busy", 32'(arb_busy), 32'd1);
        req = 2'b00;
        tick();
        chk("t4_ack0", 32'(req_ack), 32'b01);
        tick();
        chk("t4_ack_clr", 32'(req_ack), 32'd0);

        // Count 3 saturates to 2; data latched at grant; req dropped mid-message; slow transmitter
        req_data  = 32'hBEEF_0000;
        req_bytes = 4'b1100;
        req       = 2'b10;
        tick();
        chk("t5_gid", 32'(grant_id), 32'd1);
        req_data = '0;
        req      = 2'b00;
        tick();
        chk("t5_data0", 32'(tx_parallel_data), 32'hEF);
        tick();
        serve_byte("t5b0", 8'hEF, 5, 3);
        tick();
        chk("t5_data1", 32'(tx_parallel_data), 32'hBE);
        chk("t5_valid_send", 32'(tx_data_valid), 32'd0);
        tick();
        serve_byte("t5b1", 8'hBE, 5, 3);
        tick();
        chk("t5_ack", 32'(req_ack), 32'b10);
        chk("t5_valid_ack", 32'(tx_data_valid), 32'd0);
        tick();
        chk("t5_ack_clr", 32'(req_ack), 32'd0);
        chk("t5_idle", 32'(arb_busy), 32'd0);

        // tx_busy never rises
        req_data  = 32'h0000_0077;
        req_bytes = 4'b0001;
        req       = 2'b01;
        tick();
        tick();
        chk("t6_data", 32'(tx_parallel_data), 32'h77);
        tick();
        chk("t6_valid", 32'(tx_data_valid), 32'd1);
`ifdef UART_TX_ARB_TIMEOUT_EN
        for (int i = 1; i < 64; i++) begin
            tick();
            chk("t6_valid_hold", 32'(tx_data_valid), 32'd1);
        end
        tick();
        chk("t6_valid_drop", 32'(tx_data_valid), 32'd0);
        chk("t6_terr", 32'(timeout_error), 32'd1);
        chk("t6_ack", 32'(req_ack), 32'b01);
        req = 2'b00;
        tick();
        chk("t6_terr_sticky", 32'(timeout_error), 32'd1);
        chk("t6_idle", 32'(arb_busy), 32'd0);
`else
        for (int i = 0; i < 80; i++) tick();
        chk("t6_valid_waiting", 32'(tx_data_valid), 32'd1);
        chk("t6_terr_tied", 32'(timeout_error), 32'd0);
        chk("t6_no_ack", 32'(req_ack), 32'd0);
        reset = 1'b1;
        req   = 2'b00;
        tick();
        reset = 1'b0;
        chk("t6_rst_idle", 32'(arb_busy), 32'd0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
Shares the single UART transmitter between NUM_REQ on-chip requesters, e.g. ALU result return and register-file read return.
- Round-robin arbitrates among pending requests and latches the granted message of 1..MAX_BYTES bytes.
- Feeds the message to the transmitter byte by byte, LSB byte first, using the transmitter's data_valid/busy handshake.
- Sits between the system controller and the UART transmitter, in the transmitter's clock domain.

Parameters:
- DATA_WIDTH, 8, width of one UART byte.
- NUM_REQ, 2, number of requesters (2..8).
- MAX_BYTES, 2, maximum bytes per message.
- TIMEOUT_CYCLES, 64, cycles to wait for tx_busy to rise (optional feature only).

Ports:
- clk  in  1  transmitter-domain clock.
- reset  in  1  asynchronous, active-high reset.
- req  in  NUM_REQ  per-requester request level.
- req_data  in  NUM_REQ*MAX_BYTES*DATA_WIDTH  per-requester message; byte 0 in the lowest bits.
- req_bytes  in  NUM_REQ*$clog2(MAX_BYTES+1)  per-requester byte count.
- req_ack  out  NUM_REQ  one-cycle completion pulse to the granted requester.
- tx_busy  in  1  transmitter busy.
- tx_data_valid  out  1  request to transmitter.
- tx_parallel_data  out  DATA_WIDTH  byte to transmitter.
- arb_busy  out  1  high whenever state != IDLE.
- grant_id  out  $clog2(NUM_REQ)  index of the current/last granted requester.
- timeout_error  out  1  sticky error flag.

Behaviour:
Reset values:
- All outputs 0.
- Round-robin pointer = 0; state = IDLE.
- Reset asserted mid-message abandons the message, with no ack.

States IDLE -> GRANT -> SEND -> WAIT_START -> WAIT_DONE -> (SEND | ACK) -> IDLE.

IDLE:
- If any req is high and tx_busy=0, select the first requester at or after the pointer, wrapping modulo NUM_REQ.
- Register grant_id, latch its req_data and req_bytes, clear the byte index, and go to GRANT.

GRANT:
- If the latched byte count is 0, go to ACK.
- Otherwise drive tx_parallel_data = byte[index] and go to SEND.

SEND:
- Assert tx_data_valid only while tx_busy=0; stay in SEND until that holds.
- Then go to WAIT_START.

WAIT_START:
- Hold tx_data_valid=1 until tx_busy is sampled 1, which tolerates a slower transmitter clock.
- On tx_busy=1, drop tx_data_valid and go to WAIT_DONE.

WAIT_DONE:
- tx_parallel_data is held stable, because the serializer reads it every bit time.
- On tx_busy=0, increment the index.
- If index == count, go to ACK; otherwise load the next byte and go to SEND.

ACK:
- Pulse req_ack[grant_id] for one cycle.
- Set pointer = grant_id+1, wrapping.
- Go to IDLE.

Rules:
- Counts above MAX_BYTES saturate to MAX_BYTES.
- Data is latched at grant, so the requester may change req_data after grant; req itself must stay high until ack.
- A requester that drops req mid-message still gets its message completed and acked.
- A requester that raises req in the ack cycle is sampled next cycle. The advanced pointer gives other pending requesters priority, so there is no starvation.
- Minimum latency from req to the first tx_data_valid is 3 cycles: IDLE, GRANT, SEND.

Optional Feature:
Macro UART_TX_ARB_TIMEOUT_EN.
- Defined: a counter runs in WAIT_START. If tx_busy has not risen after TIMEOUT_CYCLES cycles:
  - drop tx_data_valid;
  - set timeout_error, which stays set until reset;
  - abort the remaining bytes and go to ACK, which pulses normally.
- Undefined: no counter; WAIT_START waits indefinitely; timeout_error is tied to 0.

Decomposition:
- Package uart_tx_arb_pkg holds:
  - state encoding localparams;
  - the byte-count width function;
  - the default TIMEOUT_CYCLES.
- One natural sub-module, rr_priority_picker: a combinational round-robin select from req vector and pointer to a one-hot grant and an index.

Test Plan:
- Single message: req[0]=1, bytes=2, data=16'hA55A, transmitter model busy for 11 cycles per byte -> tx_parallel_data 8'h5A then 8'hA5; req_ack[0] pulses once after the second busy fall.
- Contention: req[0] and req[1] both held high continuously, 1 byte each -> grants alternate 0,1,0,1; no requester is granted twice in a row.
- Zero-byte message: bytes=0 -> no tx_data_valid; req_ack pulses 2 cycles after req.
- Slow transmitter: busy rises 5 cycles after tx_data_valid -> tx_data_valid held high for all 5 cycles; byte stable until busy falls.
- Reset mid-message, asserted in WAIT_DONE of byte 0 -> all outputs 0 immediately, no req_ack; after release, IDLE and pointer = 0.
- With UART_TX_ARB_TIMEOUT_EN: busy never rises -> tx_data_valid drops after 64 cycles, timeout_error=1 and stays set, req_ack pulses.
